// File: rtl/macc_core.sv
// macc_core: square matrix multiply-accumulate engine with three on-chip
// matrices (A, B, C). It has a command port plus load and unload streams.
// The matrix dimension is n = cfg_dim + 1, up to 2^DIM_W.
// Commands: 0 load A, 1 load B, 2 compute C (= or +=) A*B, 3 unload C.
module macc_core #(
  parameter int DATA_W = 32,
  parameter int DIM_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_acc,
  input  logic [DIM_W-1:0]  cfg_dim,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int AW    = 2 * DIM_W;
  localparam int DEPTH = 1 << AW;
  localparam int NBANK = 3;
  localparam int BANK_A = 0;
  localparam int BANK_B = 1;
  localparam int BANK_C = 2;
  localparam logic [DIM_W-1:0] IDX_ONE  = DIM_W'(1);
  localparam logic [DIM_W-1:0] IDX_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    UNLOAD,
    DONE
  } state_t;

  state_t            state_reg;
  logic [1:0]        op_reg;
  logic              acc_mode_reg;
  logic [DIM_W-1:0]  dim_reg;
  logic [DIM_W-1:0]  i_reg, j_reg, k_reg;
  logic [DIM_W-1:0]  i_next, j_next, k_next;
  logic [DATA_W-1:0] sum_reg;
  logic              fill_done_reg;

  logic              cmd_ready_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              busy_reg;
  logic              done_reg;

  // Memory bank ports (A, B, C)
  logic [AW-1:0]     rd_addr [NBANK];
  logic [DATA_W-1:0] rd_data [NBANK];
  logic              wr_en   [NBANK];
  logic [AW-1:0]     wr_addr [NBANK];
  logic [DATA_W-1:0] wr_data [NBANK];

  logic              load_beat;
  logic              load_out;
  logic              last_ij;
  logic              last_ijk;
  logic [DATA_W-1:0] mac_base;
  logic [DATA_W-1:0] mac_prod;
  logic [DATA_W-1:0] mac_sum;

  // Row-major step of a (row, col) pair within the active n x n region.
  function automatic logic [AW-1:0] step_pair(input logic [DIM_W-1:0] r,
                                              input logic [DIM_W-1:0] c,
                                              input logic [DIM_W-1:0] dim);
    if (c == dim) return {r + IDX_ONE, IDX_ZERO};
    else          return {r, c + IDX_ONE};
  endfunction

  // Block-RAM style banks: synchronous write, registered read, no reset.
  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] rd_q;

      // One write port and one registered read port per bank
      always_ff @(posedge clk) begin
        if (wr_en[gi]) mem[wr_addr[gi]] <= wr_data[gi];
        rd_q <= mem[rd_addr[gi]];
      end

      assign rd_data[gi] = rd_q;
    end
  endgenerate

  assign load_beat = (state_reg == LOAD) && in_valid && in_ready_reg;
  assign last_ij   = (i_reg == dim_reg) && (j_reg == dim_reg);
  assign last_ijk  = last_ij && (k_reg == dim_reg);

  // The MAC operates on operands fetched one edge earlier from the next indices.
  assign mac_base = (k_reg == IDX_ZERO) ? (acc_mode_reg ? rd_data[BANK_C] : '0) : sum_reg;
  assign mac_prod = rd_data[BANK_A] * rd_data[BANK_B];
  assign mac_sum  = mac_base + mac_prod;

  // Next loop indices; they also drive the read addresses so data is ready on arrival
  always_comb begin
    i_next   = i_reg;
    j_next   = j_reg;
    k_next   = k_reg;
    load_out = 1'b0;
    case (state_reg)
      IDLE: begin
        i_next = '0;
        j_next = '0;
        k_next = '0;
      end
      LOAD: begin
        if (in_valid && in_ready_reg) {i_next, j_next} = step_pair(i_reg, j_reg, dim_reg);
      end
      COMPUTE: begin
        if (k_reg == dim_reg) begin
          k_next = '0;
          {i_next, j_next} = step_pair(i_reg, j_reg, dim_reg);
        end else begin
          k_next = k_reg + IDX_ONE;
        end
      end
      UNLOAD: begin
        // (i, j) names the element sitting in the C read register; advance when
        // it moves into the output register.
        load_out = !fill_done_reg && (!out_valid_reg || out_ready);
        if (load_out) {i_next, j_next} = step_pair(i_reg, j_reg, dim_reg);
      end
      default: begin
        i_next = i_reg;
      end
    endcase
  end

  assign rd_addr[BANK_A] = {i_next, k_next};
  assign rd_addr[BANK_B] = {k_next, j_next};
  assign rd_addr[BANK_C] = {i_next, j_next};

  // Writes: streamed loads into A/B, final dot product into C; suppressed in reset.
  assign wr_en[BANK_A]   = load_beat && (op_reg == 2'd0) && !rst;
  assign wr_en[BANK_B]   = load_beat && (op_reg == 2'd1) && !rst;
  assign wr_en[BANK_C]   = (state_reg == COMPUTE) && (k_reg == dim_reg) && !rst;
  assign wr_addr[BANK_A] = {i_reg, j_reg};
  assign wr_addr[BANK_B] = {i_reg, j_reg};
  assign wr_addr[BANK_C] = {i_reg, j_reg};
  assign wr_data[BANK_A] = in_data;
  assign wr_data[BANK_B] = in_data;
  assign wr_data[BANK_C] = mac_sum;

  // Command FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_reg        <= 2'd0;
      acc_mode_reg  <= 1'b0;
      dim_reg       <= '0;
      i_reg         <= '0;
      j_reg         <= '0;
      k_reg         <= '0;
      sum_reg       <= '0;
      fill_done_reg <= 1'b0;
      cmd_ready_reg <= 1'b1;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      i_reg    <= i_next;
      j_reg    <= j_next;
      k_reg    <= k_next;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid && cmd_ready_reg) begin
            op_reg        <= cmd_op;
            acc_mode_reg  <= cmd_acc;
            dim_reg       <= cfg_dim;
            fill_done_reg <= 1'b0;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            case (cmd_op)
              2'd0, 2'd1: begin
                state_reg    <= LOAD;
                in_ready_reg <= 1'b1;
              end
              2'd2:    state_reg <= COMPUTE;
              default: state_reg <= UNLOAD;
            endcase
          end else begin
            cmd_ready_reg <= 1'b1;
          end
        end
        LOAD: begin
          if (load_beat && last_ij) begin
            state_reg    <= DONE;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b1;
          end
        end
        COMPUTE: begin
          sum_reg <= mac_sum;
          if (last_ijk) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        UNLOAD: begin
          if (load_out) begin
            out_data_reg  <= rd_data[BANK_C];
            out_valid_reg <= 1'b1;
            if (last_ij) fill_done_reg <= 1'b1;
          end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
          end
          // Once the last element is in the output register, its handshake ends the command
          if (out_valid_reg && out_ready && fill_done_reg) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg     <= IDLE;
          cmd_ready_reg <= 1'b1;
        end
        default: begin
          state_reg     <= IDLE;
          cmd_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  // Outputs read as zero for as long as reset is held, not only after its first edge.
  assign cmd_ready = cmd_ready_reg & ~rst;
  assign in_ready  = in_ready_reg & ~rst;
  assign out_valid = out_valid_reg & ~rst;
  assign out_data  = out_data_reg & {DATA_W{~rst}};
  assign busy      = busy_reg & ~rst;
  assign done      = done_reg & ~rst;

endmodule

// File: tb/tb_macc_core.sv
// Directed testbench for macc_core: 2x2 multiply, accumulate, wrap/signed,
// unload backpressure, reset mid-load and a command presented while busy.
module tb_macc_core;

  localparam int DATA_W = 32;
  localparam int DIM_W  = 3;

  typedef logic [DATA_W-1:0] word_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  logic              cmd_acc = 1'b0;
  logic [DIM_W-1:0]  cfg_dim = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  macc_core #(.DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_acc   (cmd_acc),
    .cfg_dim   (cfg_dim),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  // Waits (bounded) for cmd_ready, presents the command for one cycle, then
  // scrambles cmd_acc/cfg_dim so the DUT must rely on its latched copies.
  // Returns one cycle after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic acc, input logic [DIM_W-1:0] dim,
                          output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_acc   = acc;
    cfg_dim   = dim;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_acc   = ~acc;
    cfg_dim   = ~dim;
    $display("cmd op=%0d acc=%0d dim=%0d accepted=%0d", op, acc, dim, ok);
  endtask

  // Load command with one idle gap before the second beat (driving junk data).
  task automatic load_mat(input logic [1:0] op, input logic [DIM_W-1:0] dim, input word_t v[4],
                          input int nbeats, output bit ok, output bit done_ok);
    bit cmd_ok;
    send_cmd(op, 1'b0, dim, cmd_ok);
    ok = cmd_ok;
    for (int b = 0; b < nbeats; b++) begin
      if (b == 1) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = v[b];
      begin : wait_ready
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 16; t++) begin
          if (in_ready === 1'b1) begin
            seen = 1'b1;
            break;
          end
          @(posedge clk); #1;
        end
        if (!seen) ok = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    done_ok = (done === 1'b1);
    $display("load op=%0d beats=%0d done=%b", op, nbeats, done);
  endtask

  // Compute command; lat counts cycles from the accept cycle to the done cycle.
  task automatic run_compute(input logic acc, input logic [DIM_W-1:0] dim,
                             output bit ok, output int lat, output bit mid_ok);
    send_cmd(2'd2, acc, dim, ok);
    mid_ok = (busy === 1'b1) && (cmd_ready === 1'b0);
    lat = 0;
    for (int t = 1; t <= 600; t++) begin
      if (done === 1'b1) begin
        lat = t;
        break;
      end
      @(posedge clk); #1;
    end
    $display("compute acc=%0d dim=%0d latency=%0d", acc, dim, lat);
  endtask

  // Collects unload beats starting one cycle after accept. With pat_en the
  // out_ready sequence 1,0,0,1,0,1,1 is applied, then held high.
  task automatic collect_unload(input int nbeats, input bit pat_en, output word_t got[4],
                                output int cnt, output int first_idx, output int last_idx,
                                output bit stable_ok, output bit done_ok);
    bit    pat [7];
    bit    have_stall;
    word_t stall_data;
    pat        = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    cnt        = 0;
    first_idx  = -1;
    last_idx   = -1;
    stable_ok  = 1'b1;
    have_stall = 1'b0;
    stall_data = '0;
    for (int b = 0; b < 4; b++) got[b] = 'x;
    for (int t = 0; t < 64 && cnt < nbeats; t++) begin
      out_ready = (pat_en && t < 7) ? pat[t] : 1'b1;
      if (have_stall && (out_valid !== 1'b1 || out_data !== stall_data)) stable_ok = 1'b0;
      have_stall = 1'b0;
      if (out_valid === 1'b1) begin
        if (first_idx < 0) first_idx = t;
        if (out_ready) begin
          got[cnt] = out_data;
          cnt++;
          last_idx = t;
        end else begin
          have_stall = 1'b1;
          stall_data = out_data;
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    done_ok = (done === 1'b1);
    $display("unload beats=%0d first=%0d last=%0d done=%b", cnt, first_idx, last_idx, done);
  endtask

  task automatic unload_mat(input logic [DIM_W-1:0] dim, input int nbeats, input bit pat_en,
                            output bit ok, output word_t got[4], output int cnt,
                            output int first_idx, output int last_idx,
                            output bit stable_ok, output bit done_ok);
    send_cmd(2'd3, 1'b0, dim, ok);
    collect_unload(nbeats, pat_en, got, cnt, first_idx, last_idx, stable_ok, done_ok);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: cmd_ready=%b busy=%b expected 1/0", cmd_ready, busy); end
    $display("reset released");
  endtask

  task automatic test_basic_2x2;
    word_t va[4], vb[4], exp_c[4], got[4];
    bit ok, dn, mid, stable;
    int lat, cnt, fi, li;
    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    exp_c = '{32'd19, 32'd22, 32'd43, 32'd50};
    load_mat(2'd0, 3'd1, va, 4, ok, dn);
    checks++; if (!ok || !dn) begin errors++; $display("FAIL basic_load_a: ok=%b done=%b expected 1/1", ok, dn); end
    load_mat(2'd1, 3'd1, vb, 4, ok, dn);
    checks++; if (!ok || !dn) begin errors++; $display("FAIL basic_load_b: ok=%b done=%b expected 1/1", ok, dn); end
    run_compute(1'b0, 3'd1, ok, lat, mid);
    checks++; if (lat != 9) begin errors++; $display("FAIL basic_compute_latency: got %0d expected 9", lat); end
    checks++; if (!mid) begin errors++; $display("FAIL basic_compute_busy: got busy=%b cmd_ready=%b expected 1/0", busy, cmd_ready); end
    unload_mat(3'd1, 4, 1'b0, ok, got, cnt, fi, li, stable, dn);
    checks++; if (cnt != 4) begin errors++; $display("FAIL basic_unload_count: got %0d expected 4", cnt); end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got[b] !== exp_c[b]) begin errors++; $display("FAIL basic_unload[%0d]: got %h expected %h", b, got[b], exp_c[b]); end
    end
    checks++; if (fi < 0 || fi > 1) begin errors++; $display("FAIL basic_first_valid: got cycle %0d expected <= 2 after accept", fi + 1); end
    checks++; if (li - fi != 3) begin errors++; $display("FAIL basic_no_bubbles: got span %0d expected 3", li - fi); end
    checks++; if (!dn) begin errors++; $display("FAIL basic_unload_done: got 0 expected 1"); end
  endtask

  task automatic test_accumulate;
    word_t exp_c[4], got[4];
    bit ok, dn, mid, stable;
    int lat, cnt, fi, li;
    exp_c = '{32'd38, 32'd44, 32'd86, 32'd100};
    run_compute(1'b1, 3'd1, ok, lat, mid);
    checks++; if (lat != 9) begin errors++; $display("FAIL acc_compute_latency: got %0d expected 9", lat); end
    unload_mat(3'd1, 4, 1'b0, ok, got, cnt, fi, li, stable, dn);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got[b] !== exp_c[b]) begin errors++; $display("FAIL acc_unload[%0d]: got %h expected %h", b, got[b], exp_c[b]); end
    end
  endtask

  task automatic test_wrap_signed;
    word_t va[4], vb[4], exp_c[4], got[4];
    bit ok, dn, mid, stable;
    int lat, cnt, fi, li;
    va = '{32'h0001_0000, 32'h0, 32'h0, 32'h0};
    vb = '{32'h0001_0000, 32'h0, 32'h0, 32'h0};
    load_mat(2'd0, 3'd0, va, 1, ok, dn);
    checks++; if (!dn) begin errors++; $display("FAIL wrap_load_done_n1: got 0 expected 1"); end
    load_mat(2'd1, 3'd0, vb, 1, ok, dn);
    run_compute(1'b0, 3'd0, ok, lat, mid);
    checks++; if (lat != 2) begin errors++; $display("FAIL wrap_compute_latency_n1: got %0d expected 2", lat); end
    unload_mat(3'd0, 1, 1'b0, ok, got, cnt, fi, li, stable, dn);
    checks++; if (cnt != 1 || got[0] !== 32'h0) begin errors++; $display("FAIL wrap_modulo: got %h (beats %0d) expected 00000000 (1)", got[0], cnt); end
    va = '{32'hFFFF_FFFD, 32'h0, 32'h0, 32'h0};
    vb = '{32'h0000_0004, 32'h0, 32'h0, 32'h0};
    load_mat(2'd0, 3'd0, va, 1, ok, dn);
    load_mat(2'd1, 3'd0, vb, 1, ok, dn);
    run_compute(1'b0, 3'd0, ok, lat, mid);
    unload_mat(3'd0, 1, 1'b0, ok, got, cnt, fi, li, stable, dn);
    checks++; if (got[0] !== 32'hFFFF_FFF4) begin errors++; $display("FAIL wrap_signed: got %h expected fffffff4", got[0]); end
    // Elements outside the 1x1 region keep their accumulate-test values
    exp_c = '{32'hFFFF_FFF4, 32'd44, 32'd86, 32'd100};
    unload_mat(3'd1, 4, 1'b0, ok, got, cnt, fi, li, stable, dn);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got[b] !== exp_c[b]) begin errors++; $display("FAIL wrap_region_keep[%0d]: got %h expected %h", b, got[b], exp_c[b]); end
    end
  endtask

  task automatic test_backpressure;
    word_t exp_c[4], got[4];
    bit ok, dn, stable;
    int cnt, fi, li;
    exp_c = '{32'hFFFF_FFF4, 32'd44, 32'd86, 32'd100};
    unload_mat(3'd1, 4, 1'b1, ok, got, cnt, fi, li, stable, dn);
    checks++; if (cnt != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", cnt); end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got[b] !== exp_c[b]) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", b, got[b], exp_c[b]); end
    end
    checks++; if (!stable) begin errors++; $display("FAIL bp_stable: got unstable expected stable during stall"); end
    checks++; if (!dn) begin errors++; $display("FAIL bp_done: got 0 expected 1 one cycle after last beat"); end
  endtask

  task automatic test_reset_mid_load;
    bit ok;
    bit saw_done;
    send_cmd(2'd0, 1'b0, 3'd1, ok);
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      in_data  = 32'd9 + 32'(b);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: in_ready=%b busy=%b expected 0/0", in_ready, busy); end
    saw_done = (done === 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", cmd_ready); end
    for (int t = 0; t < 4; t++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL rst_mid_no_done: got done pulse expected none"); end
    $display("reset mid-load issued");
  endtask

  task automatic test_back_to_back;
    word_t exp_c[4], got[4];
    bit ok, dn, stable, early;
    int lat, cnt, fi, li;
    // A = [9,10,11,4] after the aborted load, B = [4,6,7,8]
    exp_c = '{32'd106, 32'd134, 32'd72, 32'd98};
    send_cmd(2'd2, 1'b0, 3'd1, ok);
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cfg_dim   = 3'd1;
    lat = 0;
    early = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      if (done === 1'b1) begin
        lat = t;
        break;
      end
      if (cmd_ready === 1'b1) early = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (lat != 9) begin errors++; $display("FAIL b2b_compute_latency: got %0d expected 9", lat); end
    checks++; if (early || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ignored_while_busy: cmd_ready seen high before idle"); end
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after_done: cmd_ready=%b busy=%b expected 1/0", cmd_ready, busy); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_accepted: busy=%b cmd_ready=%b expected 1/0", busy, cmd_ready); end
    collect_unload(4, 1'b0, got, cnt, fi, li, stable, dn);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got[b] !== exp_c[b]) begin errors++; $display("FAIL b2b_unload[%0d]: got %h expected %h", b, got[b], exp_c[b]); end
    end
  endtask

  initial begin
    test_reset;
    test_basic_2x2;
    test_accumulate;
    test_wrap_signed;
    test_backpressure;
    test_reset_mid_load;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/macc_core.md
MACC_CORE -- requirements
Module: macc_core

Interface
REQ-001 Parameter DATA_W, default 32: element width; signed two's complement.
REQ-002 Parameter DIM_W, default 3: maximum matrix dimension is 2^DIM_W (8x8); matrices are square.
REQ-003 CLK  in  1: single clock; all state changes on rising edge.
REQ-004 RST  in  1: reset, synchronous and active-high.
REQ-005 cmd_valid  in  1: command request.
REQ-006 cmd_ready  out  1: command accepted when cmd_valid and cmd_ready are both high.
REQ-007 cmd_op  in  2: 0 load A, 1 load B, 2 compute C, 3 unload C.
REQ-008 cmd_acc  in  1: compute only; 1 = C += A*B, 0 = C = A*B.
REQ-009 cfg_dim  in  DIM_W: n-1, where n is the active dimension; sampled at command accept.
REQ-010 in_valid / in_ready / in_data  in / out / in  1 / 1 / DATA_W: load stream.
REQ-011 out_valid / out_ready / out_data  out / in / out  1 / 1 / DATA_W: unload stream.
REQ-012 busy  out  1: high while a command is in progress.
REQ-013 done  out  1: one-cycle pulse when a command completes.

Function
REQ-014 The block SHALL implement the FSM states IDLE, LOAD, COMPUTE, UNLOAD and DONE.
REQ-015 IDLE: cmd_ready=1 and busy=0; on accept, go to LOAD (op 0/1), COMPUTE (op 2) or UNLOAD (op 3).
REQ-016 cmd_ready SHALL be 0 in every state except IDLE; a cmd_valid presented while busy SHALL be ignored, not queued.
REQ-017 cfg_dim and cmd_acc SHALL be latched at accept; later changes SHALL have no effect on the running command.
REQ-018 Storage: three arrays A, B, C, each 2^DIM_W x 2^DIM_W words, with element (i,j) at address i*2^DIM_W+j.
REQ-019 Elements outside the active n x n region SHALL be left unmodified.
REQ-020 LOAD: in_ready=1 throughout the state.
REQ-021 LOAD: each in_valid&in_ready beat writes the next element in row-major order, (0,0),(0,1)...(n-1,n-1).
REQ-022 LOAD: after n*n beats, go to DONE.
REQ-023 COMPUTE: one MAC per cycle in loop order i, j, k (k innermost), giving exactly n^3 MAC cycles immediately after accept.
REQ-024 COMPUTE: at k=0 the accumulator SHALL initialise to C(i,j) if cmd_acc=1, else to 0.
REQ-025 COMPUTE: on the k=n-1 cycle, the final sum SHALL be written to C(i,j).
REQ-026 Arithmetic: product and sum SHALL be truncated to the low DATA_W bits (modulo 2^DATA_W wrap), with no saturation and no overflow flag.
REQ-027 UNLOAD: C SHALL be streamed row-major, n*n beats, with out_data registered.
REQ-028 UNLOAD: while out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-029 UNLOAD: the first out_valid SHALL appear at most 2 cycles after accept; with out_ready held high, there SHALL be one beat per cycle with no bubbles.
REQ-030 DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
REQ-031 Total command time SHALL be n^3+1 cycles (compute) from accept to done, and done SHALL follow the last data beat by 1 cycle (load/unload).
REQ-032 With n=1 (cfg_dim=0), each command SHALL handle a single element with no special-casing.
REQ-033 Unloading C before any compute SHALL return the current C contents without error.

Reset
REQ-034 While RST=1, the FSM SHALL go to IDLE and the outputs SHALL be 0: cmd_ready, in_ready, out_valid, out_data, busy, done.
REQ-035 In the first cycle after RST deasserts, cmd_ready SHALL be 1.
REQ-036 Reset mid-command SHALL abort it with no done pulse.
REQ-037 Array contents SHALL NOT be cleared by reset and are undefined after power-up.

Verification
REQ-038 Basic 2x2 multiply:
- stimulus: cfg_dim=1; load A=[1,2,3,4], load B=[5,6,7,8], compute with acc=0, then unload;
- response: unload returns [19,22,43,50]; the compute done pulse occurs 9 cycles after accept.
REQ-039 Accumulate:
- stimulus: repeat the REQ-038 compute with acc=1, then unload;
- response: unload returns [38,44,86,100].
REQ-040 Wrap and signed arithmetic, cfg_dim=0:
- A=0x00010000, B=0x00010000 -> C=0x00000000;
- A=0xFFFFFFFD, B=4 -> C=0xFFFFFFF4.
REQ-041 Unload backpressure:
- stimulus: 2x2 unload with out_ready toggling 1,0,0,1,0,1,1;
- response: exactly 4 beats in order; out_data stable during stalls; done 1 cycle after the 4th beat.
REQ-042 Reset mid-load:
- stimulus: RST pulsed after 3 of 4 load beats;
- response: in_ready=0 and busy=0 in the reset cycle; no done pulse; cmd_ready=1 in the next cycle.
REQ-043 Command while busy:
- stimulus: op 3 asserted continuously during a 2x2 compute;
- response: the op is ignored until IDLE, then accepted the cycle after done.
